wiv_pipe_stage: RTL
===================

// Module: wiv_pipe_stage
// PURPOSE
//  Generic, parametrised inter-stage pipeline register for the WivCPU core. It replaces the fixed
//  IF/ID, ID/EX, EX/MEM and MEM/WB registers; the payload is any packed stage struct cast to DATA_W.
//  It adds a valid/ready handshake, an optional skid entry for fully registered backpressure,
//  a synchronous flush (branch/trap squash) and a saturating stall counter for profiling.
// PARAMETERS
//  DATA_W  96  payload width in bits (96 = PC[63:0] + instruction[31:0], the IF/ID payload)
//  DEPTH   2   1 = single register, in_ready_o combinational; 2 = main + skid entry, in_ready_o registered
//  CNT_W   32  width of the stall counter
// PORTS
//  clk          in   1       core clock
//  rst          in   1       asynchronous, active-high reset
//  flush_i      in   1       squash all held entries (synchronous)
//  in_valid_i   in   1       upstream has payload
//  in_ready_o   out  1       stage can accept payload this cycle
//  in_data_i    in   DATA_W  upstream payload
//  out_valid_o  out  1       head entry valid
//  out_ready_i  in   1       downstream accepts head entry
//  out_data_o   out  DATA_W  head entry payload
//  occupancy_o  out  2       entries held (0..DEPTH)
//  stall_cnt_o  out  CNT_W   cycles with out_valid_o=1 and out_ready_i=0, saturating
// BEHAVIOUR
//  - Reset: every output reads 0 except in_ready_o, which reads 1 (stage empty); entries cleared.
//    Reset applies immediately, including mid-transfer; held data is lost.
//  - A push occurs when in_valid_i & in_ready_o; a pop occurs when out_valid_o & out_ready_i.
//  - Latency: a payload pushed in cycle N is visible on out_data_o with out_valid_o=1 in cycle N+1.
//  - Strict FIFO order; no payload is duplicated or dropped except by flush.
//  - DEPTH=1: in_ready_o = ~full | out_ready_i (combinational path out_ready_i -> in_ready_o).
//    Push and pop in the same cycle replace the entry and keep occupancy at 1.
//  - DEPTH=2: state machine EMPTY/ONE/TWO; in_ready_o = (state != TWO), driven from a flop.
//    EMPTY: push -> ONE.
//    ONE: push & pop -> ONE (main takes new data); push only -> TWO (new data goes to skid);
//         pop only -> EMPTY.
//    TWO: pop -> ONE (skid moves to main in the same edge); no push is possible.
//    out_data_o always comes from the main entry.
//  - Flush (highest priority over push/pop): the next state is EMPTY, out_valid_o=0 and in_ready_o=1.
//    A payload presented in the flush cycle is discarded. A pop in the flush cycle is legal, and
//    the consumer may keep that payload. Payload flops are not cleared; only valid state is cleared.
//  - While empty, out_data_o holds its last value; it is don't-care while out_valid_o=0.
//  - stall_cnt_o: +1 on each clock edge where out_valid_o & ~out_ready_i, including flush cycles.
//    It saturates at 2^CNT_W-1 and is cleared only by rst.
//  - occupancy_o equals the number of valid entries, updated on the same edge as the state.
// TESTING
//  1. DEPTH=2, out_ready_i=1, push A,B,C in back-to-back cycles -> A,B,C on out_data_o in
//     cycles 1,2,3; occupancy_o=1 throughout; stall_cnt_o=0.
//  2. DEPTH=2, out_ready_i=0, push A then B -> occupancy_o=2 and in_ready_o=0. Hold C for
//     3 cycles, then raise out_ready_i -> A,B,C popped in order; stall_cnt_o=4.
//  3. DEPTH=2 at occupancy 2, assert flush_i with in_valid_i=1 (payload D) -> next cycle
//     occupancy_o=0, out_valid_o=0, in_ready_o=1; D never appears at the output.
//  4. DEPTH=1 full, out_ready_i=1, push E in the same cycle -> in_ready_o=1 combinationally;
//     next cycle out_data_o=E; occupancy_o stays 1.
//  5. Assert rst asynchronously mid-cycle at occupancy 2 -> outputs take reset values before
//     the next clock edge; after release, a push of F gives out_data_o=F one cycle later.
//  6. CNT_W=4, hold out_valid_o=1 and out_ready_i=0 for 20 cycles -> stall_cnt_o=15 (saturated).

Source files
------------

// File: rtl/wiv_pipe_stage.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall counter.
module wiv_pipe_stage #(
    parameter int DATA_W = 96,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_push;
    logic              w_pop;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_skid_to_main;

    assign out_valid_o = (r_state != S_EMPTY);
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_nxt    = r_state;
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = S_ONE;
                        w_load_main = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_load_main = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt = S_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_state_nxt    = S_ONE;
                        w_skid_to_main = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: payload flops are reset so out_data_o reads 0 after reset; flush leaves them untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= in_data_i;
            end else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid_o && !out_ready_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Single entry: ready passes straight through from downstream; two entries: registered ready.
    generate
        if (DEPTH == 1) begin : g_single
            assign in_ready_o = (r_state == S_EMPTY) | out_ready_i;
        end else begin : g_skid
            logic r_in_ready;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != S_TWO);
                end
            end
            assign in_ready_o = r_in_ready;
        end
    endgenerate

    assign out_data_o  = r_main;
    assign occupancy_o = r_state;
    assign stall_cnt_o = r_stall_cnt;

endmodule
